// File: rtl/hub_pkg.sv
// Shared types and arithmetic for the sensor fusion hub and its command path.
package hub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILTER,
      OUT
   } hub_state_t;

   localparam int HUB_NCH = 4;
   localparam int CHW     = $clog2(HUB_NCH);

   // Widened EMA step: inputs zero-extended to 32 bits, caller truncates to its sample width.
   // The arithmetic shift floors toward -inf, so the result always lies between filt and x.
   function automatic logic [31:0] ema_step(input logic [31:0] filt,
                                            input logic [31:0] x,
                                            input int          shift);
      logic signed [32:0] diff;
      diff = $signed({1'b0, x}) - $signed({1'b0, filt});
      diff = diff >>> shift;
      return filt + diff[31:0];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at N.
module rr_arbiter #(
   parameter int N = 4,
   localparam int CW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [CW-1:0] ptr,
   output logic [CW-1:0] grant_idx,
   output logic          any_grant
);

   // Scan from the farthest offset down so the nearest requester is written last and wins.
   always_comb begin
      int j;
      j         = 0;
      grant_idx = '0;
      any_grant = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= N) begin
            j = j - N;
         end
         if (req[j]) begin
            grant_idx = CW'(j);
            any_grant = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sensor_fusion_hub.sv
// Multi-channel sample filter: per-channel capture and staleness, one shared EMA datapath,
// round-robin service and a single valid/ready result port.
module sensor_fusion_hub
   import hub_pkg::*;
#(
   parameter int NCH            = HUB_NCH,
   parameter int W              = 8,
   parameter int ALPHA_SHIFT    = 2,
   parameter int TIMEOUT_CYCLES = 12_500_000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NCH-1:0]          in_valid,
   input  logic [NCH*W-1:0]        in_data,
   input  logic [NCH-1:0]          cfg_bypass,
   input  logic                    clr_overrun,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(NCH)-1:0]  out_ch,
   output logic [W-1:0]            out_data,
   output logic [NCH*W-1:0]        filt_data,
   output logic [NCH-1:0]          stale,
   output logic [NCH-1:0]          overrun
);

   localparam int            CW          = $clog2(NCH);
   localparam int            TW          = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);

   hub_state_t     state;
   logic [CW-1:0]  rr_ptr;
   logic [CW-1:0]  grant_idx;
   logic [CW-1:0]  cur_ch;
   logic           any_grant;
   logic           grant_fire;
   logic [W-1:0]   cur_x;
   logic [W-1:0]   filt_y;
   logic [W-1:0]   hold     [NCH];
   logic [W-1:0]   filt     [NCH];
   logic [TW-1:0]  idle_cnt [NCH];
   logic [NCH-1:0] pending;
   logic [NCH-1:0] seeded;
   logic [NCH-1:0] timeout_hit;
   logic [NCH-1:0] granted_now;

   rr_arbiter #(.N(NCH)) u_arb (
      .req       (pending),
      .ptr       (rr_ptr),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   assign grant_fire = (state == IDLE) && any_grant;

   always_comb begin
      granted_now = '0;
      timeout_hit = '0;
      filt_data   = '0;
      for (int c = 0; c < NCH; c++) begin
         granted_now[c]        = grant_fire && (grant_idx == CW'(c));
         timeout_hit[c]        = !in_valid[c] && (idle_cnt[c] == TIMEOUT_VAL - 1'b1);
         filt_data[c*W +: W]   = filt[c];
      end
   end

   // An unseeded (fresh or timed-out) channel takes its first sample raw instead of
   // smoothing toward a value that no longer means anything.
   always_comb begin
      filt_y = cur_x;
      if (!cfg_bypass[cur_ch] && seeded[cur_ch]) begin
         filt_y = W'(ema_step(32'(filt[cur_ch]), 32'(cur_x), ALPHA_SHIFT));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            hold[c]     <= '0;
            idle_cnt[c] <= TIMEOUT_VAL;
         end
         pending <= '0;
         seeded  <= '0;
         stale   <= '1;
         overrun <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (in_valid[c]) begin
               hold[c]     <= in_data[c*W +: W];
               pending[c]  <= 1'b1;
               idle_cnt[c] <= '0;
               stale[c]    <= 1'b0;
            end else begin
               if (granted_now[c]) begin
                  pending[c] <= 1'b0;
               end
               if (idle_cnt[c] != TIMEOUT_VAL) begin
                  idle_cnt[c] <= idle_cnt[c] + 1'b1;
               end
               if (timeout_hit[c]) begin
                  stale[c] <= 1'b1;
               end
            end

            // A sample landing on its own grant edge is not lost, so it is not an overrun.
            if (in_valid[c] && pending[c] && !granted_now[c]) begin
               overrun[c] <= 1'b1;
            end else if (clr_overrun) begin
               overrun[c] <= 1'b0;
            end

            if (timeout_hit[c]) begin
               seeded[c] <= 1'b0;
            end else if ((state == FILTER) && (cur_ch == CW'(c))) begin
               seeded[c] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_ch    <= '0;
         cur_x     <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
         for (int c = 0; c < NCH; c++) begin
            filt[c] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (any_grant) begin
                  cur_ch <= grant_idx;
                  cur_x  <= hold[grant_idx];
                  rr_ptr <= (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
                  state  <= FILTER;
               end
            end
            FILTER: begin
               filt[cur_ch] <= filt_y;
               out_data     <= filt_y;
               out_ch       <= cur_ch;
               out_valid    <= 1'b1;
               state        <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_fusion_hub.sv
// Scoreboard bench for sensor_fusion_hub: expected results are queued when samples are
// driven and compared in channel/value order as the hub hands them off.
module tb_sensor_fusion_hub;

   localparam int NCH   = 4;
   localparam int W     = 8;
   localparam int SHIFT = 2;
   localparam int TMO   = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [NCH-1:0]   in_valid;
   logic [NCH*W-1:0] in_data;
   logic [NCH-1:0]   cfg_bypass;
   logic             clr_overrun;
   logic             out_valid;
   logic             out_ready;
   logic [1:0]       out_ch;
   logic [W-1:0]     out_data;
   logic [NCH*W-1:0] filt_data;
   logic [NCH-1:0]   stale;
   logic [NCH-1:0]   overrun;

   typedef struct packed {
      logic [1:0] ch;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         tests = 0;
   int         fails = 0;
   logic       prev_stall = 1'b0;
   logic [1:0] prev_ch;
   logic [7:0] prev_data;

   sensor_fusion_hub #(
      .NCH(NCH), .W(W), .ALPHA_SHIFT(SHIFT), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .cfg_bypass  (cfg_bypass),
      .clr_overrun (clr_overrun),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ch      (out_ch),
      .out_data    (out_data),
      .filt_data   (filt_data),
      .stale       (stale),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference EMA using floor division, independent of the shift-based hardware form.
   function automatic int emaModel(input int f, input int x);
      int d;
      int q;
      int div;
      div = 1 << SHIFT;
      d   = x - f;
      if (d >= 0) q = d / div;
      else        q = -((-d + div - 1) / div);
      return f + q;
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && out_valid) begin
            checkOutput("stall_ch", 32'(out_ch), 32'(prev_ch));
            checkOutput("stall_data", 32'(out_data), 32'(prev_data));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_out", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               checkOutput("out_ch", 32'(out_ch), 32'(mon_e.ch));
               checkOutput("out_data", 32'(out_data), 32'(mon_e.data));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_ch    = out_ch;
         prev_data  = out_data;
      end
   end

   task automatic doReset();
      @(posedge clk); #1;
      reset       = 1'b1;
      in_valid    = '0;
      clr_overrun = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic driveSample(input int ch, input int d);
      @(posedge clk); #1;
      in_valid[ch]        = 1'b1;
      in_data[ch*W +: W]  = 8'(d);
      @(posedge clk); #1;
      in_valid[ch] = 1'b0;
   endtask

   task automatic applyStimulus(input int ch, input int d, input int exp, input bit checkLat);
      exp_t e;
      e.ch   = 2'(ch);
      e.data = 8'(exp);
      sb.push_back(e);
      driveSample(ch, d);
      if (checkLat) begin
         checkOutput("lat_e0", 32'(out_valid), 32'd0);
         @(posedge clk); #1;
         checkOutput("lat_e1", 32'(out_valid), 32'd0);
         @(posedge clk); #1;
         checkOutput("lat_e2", 32'(out_valid), 32'd1);
      end
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0 || out_valid) begin
         checkOutput("drain_timeout", 32'd1, 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      in_valid    = '0;
      in_data     = '0;
      cfg_bypass  = '0;
      clr_overrun = 1'b0;
      out_ready   = 1'b1;
      reset       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_ch", 32'(out_ch), 32'd0);
      checkOutput("rst_data", 32'(out_data), 32'd0);
      checkOutput("rst_filt", filt_data, 32'd0);
      checkOutput("rst_stale", 32'(stale), 32'hF);
      checkOutput("rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;

      // Seed then smooth on channel 0.
      applyStimulus(0, 100, 100, 1'b1);
      waitIdle(20);
      applyStimulus(0, 20, emaModel(100, 20), 1'b1);
      waitIdle(20);
      applyStimulus(0, 20, emaModel(80, 20), 1'b1);
      waitIdle(20);
      checkOutput("filt0", 32'(filt_data[7:0]), 32'd65);

      // Bypass on channel 1.
      cfg_bypass[1] = 1'b1;
      checkOutput("stale1_pre", 32'(stale[1]), 32'd1);
      applyStimulus(1, 200, 200, 1'b1);
      checkOutput("stale1_post", 32'(stale[1]), 32'd0);
      waitIdle(20);
      applyStimulus(1, 10, 10, 1'b1);
      waitIdle(20);
      cfg_bypass = '0;

      // All channels at once under backpressure.
      doReset();
      out_ready = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         mon_e.ch   = 2'(c);
         mon_e.data = 8'(11 * (c + 1));
         sb.push_back(mon_e);
      end
      @(posedge clk); #1;
      in_valid = '1;
      in_data  = {8'd44, 8'd33, 8'd22, 8'd11};
      @(posedge clk); #1;
      in_valid = '0;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("rr_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("rr_hold_ch", 32'(out_ch), 32'd0);
      out_ready = 1'b1;
      waitIdle(40);
      checkOutput("rr_overrun", 32'(overrun), 32'd0);
      checkOutput("rr_filt", filt_data, 32'h2C21160B);

      // Overrun on channel 2 while the hub is stalled on channel 0.
      doReset();
      out_ready = 1'b0;
      applyStimulus(0, 5, 5, 1'b0);
      driveSample(2, 50);
      driveSample(2, 60);
      mon_e.ch   = 2'd2;
      mon_e.data = 8'd60;
      sb.push_back(mon_e);
      checkOutput("ovr_set", 32'(overrun), 32'h4);
      out_ready = 1'b1;
      waitIdle(30);
      checkOutput("ovr_sticky", 32'(overrun), 32'h4);
      @(posedge clk); #1;
      clr_overrun = 1'b1;
      @(posedge clk); #1;
      clr_overrun = 1'b0;
      checkOutput("ovr_clr", 32'(overrun), 32'd0);

      // Second sample arriving exactly on the grant edge.
      doReset();
      out_ready  = 1'b1;
      mon_e.ch   = 2'd2;
      mon_e.data = 8'd70;
      sb.push_back(mon_e);
      mon_e.data = 8'(emaModel(70, 80));
      sb.push_back(mon_e);
      @(posedge clk); #1;
      in_valid[2]   = 1'b1;
      in_data[23:16] = 8'd70;
      @(posedge clk); #1;
      in_data[23:16] = 8'd80;
      @(posedge clk); #1;
      in_valid[2] = 1'b0;
      waitIdle(30);
      checkOutput("coinc_overrun", 32'(overrun), 32'd0);

      // Timeout and re-seed on channel 3.
      doReset();
      out_ready = 1'b1;
      applyStimulus(3, 100, 100, 1'b1);
      repeat (13) @(posedge clk);
      #1;
      checkOutput("stale3_before", 32'(stale[3]), 32'd0);
      @(posedge clk); #1;
      checkOutput("stale3_hit", 32'(stale[3]), 32'd1);
      applyStimulus(3, 0, 0, 1'b1);
      checkOutput("stale3_clear", 32'(stale[3]), 32'd0);
      waitIdle(20);

      // Reset while a result is held in OUT.
      doReset();
      out_ready = 1'b0;
      driveSample(1, 9);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("mid_valid", 32'(out_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_valid", 32'(out_valid), 32'd0);
      checkOutput("async_ch", 32'(out_ch), 32'd0);
      checkOutput("async_data", 32'(out_data), 32'd0);
      checkOutput("async_filt", filt_data, 32'd0);
      checkOutput("async_stale", 32'(stale), 32'hF);
      checkOutput("async_overrun", 32'(overrun), 32'd0);
      @(posedge clk); #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("post_rst_valid", 32'(out_valid), 32'd0);

      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
